param_serializer: RTL and testbench

Parametrised parallel-to-serial shifter. It is the next-generation data serializer for the UART_TX path and for other serial links in the system. It adds configurable width, a runtime frame length, LSB/MSB-first ordering, a valid/ready load handshake and parity generation at load time. Shift timing comes from an external bit-tick enable, so the parent FSM or baud generator controls the bit period.

---
 rtl/param_serializer.sv | 147 ++++++++++++++
 tb/tb_param_serializer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/param_serializer.sv
// param_serializer: parallel-to-serial shifter with a runtime frame length,
// selectable bit order, a valid/ready load handshake and load-time parity.
// Bit timing is set by the external ser_EN tick, so the bit period follows
// whatever tick rate the parent baud generator or FSM provides.
module param_serializer #(
    parameter int   DATA_WIDTH = 8,
    parameter int   CNT_WIDTH  = 4,
    parameter int   MSB_FIRST  = 0,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_Data,
    input  logic [CNT_WIDTH-1:0]  Frame_Len,
    input  logic                  Par_Type,
    input  logic                  Data_Valid,
    output logic                  Data_Ready,
    input  logic                  ser_EN,
    output logic                  ser_OUT,
    output logic                  ser_Done,
    output logic                  ser_Busy,
    output logic [CNT_WIDTH-1:0]  counter_ser,
    output logic                  Par_Bit
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] FULL_LEN = CNT_WIDTH'(DATA_WIDTH);

    state_t                  state_q,  state_d;
    logic [DATA_WIDTH-1:0]   shreg_q,  shreg_d;
    logic [CNT_WIDTH-1:0]    len_q,    len_d;
    logic [CNT_WIDTH-1:0]    cnt_q,    cnt_d;
    logic                    out_q,    out_d;
    logic                    done_q,   done_d;
    logic                    par_q,    par_d;

    logic [CNT_WIDTH-1:0]    load_len;
    logic [DATA_WIDTH-1:0]   load_mask;
    logic                    load_par;
    logic [CNT_WIDTH-1:0]    bit_idx;
    logic [DATA_WIDTH-1:0]   bit_sel;
    logic                    next_bit;

    // Effective frame length: 0 or anything wider than the register means "full word".
    always_comb begin
        if ((Frame_Len == '0) || (Frame_Len > FULL_LEN)) begin
            load_len = FULL_LEN;
        end else begin
            load_len = Frame_Len;
        end
    end

    // Mask of the bits that belong to the frame (only these feed parity),
    // and a one-hot mux picking the bit to present next from the held word.
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bits
            assign load_mask[gi] = (CNT_WIDTH'(gi) < load_len);
            assign bit_sel[gi]   = (bit_idx == CNT_WIDTH'(gi)) & shreg_q[gi];
        end
    endgenerate

    assign load_par = (^(P_Data & load_mask)) ^ Par_Type;
    assign next_bit = |bit_sel;

    // Index of the next bit to present; counter_ser is the number already sent.
    always_comb begin
        if (MSB_FIRST != 0) begin
            bit_idx = len_q - cnt_q - CNT_WIDTH'(1);
        end else begin
            bit_idx = cnt_q;
        end
    end

    // Next-state logic: load in IDLE, advance one bit per tick in SHIFT,
    // and spend one extra tick after the last bit to close the frame.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        done_d  = 1'b0;
        par_d   = par_q;
        case (state_q)
            IDLE: begin
                if (Data_Valid) begin
                    shreg_d = P_Data;
                    len_d   = load_len;
                    par_d   = load_par;
                    cnt_d   = '0;
                    out_d   = IDLE_LEVEL;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_EN) begin
                    if (cnt_q < len_q) begin
                        out_d = next_bit;
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end else begin
                        done_d  = 1'b1;
                        out_d   = IDLE_LEVEL;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over everything, including a
    // frame in flight, and never produces a done pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            shreg_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            out_q   <= IDLE_LEVEL;
            done_q  <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
            par_q   <= par_d;
        end
    end

    assign Data_Ready  = (state_q == IDLE);
    assign ser_Busy    = (state_q == SHIFT);
    assign ser_OUT     = out_q;
    assign ser_Done    = done_q;
    assign counter_ser = cnt_q;
    assign Par_Bit     = par_q;

endmodule

// File: tb/tb_param_serializer.sv
// Testbench for param_serializer: one LSB-first and one MSB-first instance,
// directed scenarios followed by random frames checked against a model that
// derives the expected bit order, parity and tick timing from the frame rules.
module tb_param_serializer;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0][7:0] p_data;
    logic [1:0][3:0] frame_len;
    logic [1:0]      par_type;
    logic [1:0]      data_valid;
    logic [1:0]      ser_en;
    logic [1:0]      data_ready;
    logic [1:0]      ser_out;
    logic [1:0]      ser_done;
    logic [1:0]      ser_busy;
    logic [1:0][3:0] counter;
    logic [1:0]      par_bit;

    int tests  = 0;
    int failed = 0;
    int done_seen0 = 0;

    always #5 clk = ~clk;

    param_serializer #(.DATA_WIDTH(8), .CNT_WIDTH(4), .MSB_FIRST(0), .IDLE_LEVEL(1'b1)) dut_lsb (
        .CLK(clk), .RST(rst), .P_Data(p_data[0]), .Frame_Len(frame_len[0]),
        .Par_Type(par_type[0]), .Data_Valid(data_valid[0]), .Data_Ready(data_ready[0]),
        .ser_EN(ser_en[0]), .ser_OUT(ser_out[0]), .ser_Done(ser_done[0]),
        .ser_Busy(ser_busy[0]), .counter_ser(counter[0]), .Par_Bit(par_bit[0])
    );

    param_serializer #(.DATA_WIDTH(8), .CNT_WIDTH(4), .MSB_FIRST(1), .IDLE_LEVEL(1'b1)) dut_msb (
        .CLK(clk), .RST(rst), .P_Data(p_data[1]), .Frame_Len(frame_len[1]),
        .Par_Type(par_type[1]), .Data_Valid(data_valid[1]), .Data_Ready(data_ready[1]),
        .ser_EN(ser_en[1]), .ser_OUT(ser_out[1]), .ser_Done(ser_done[1]),
        .ser_Busy(ser_busy[1]), .counter_ser(counter[1]), .Par_Bit(par_bit[1])
    );

    // Count done pulses on the LSB instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (ser_done[0] === 1'b1) done_seen0 <= done_seen0 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int eff_len(input logic [3:0] fl);
        if (fl == 4'd0 || fl > 4'd8) return 8;
        return int'(fl);
    endfunction

    function automatic logic ref_par(input logic [7:0] d, input logic [3:0] fl, input logic pt);
        int n;
        int ones;
        n = eff_len(fl);
        ones = 0;
        for (int k = 0; k < n; k++) ones += int'(d[k]);
        return logic'(ones % 2) ^ pt;
    endfunction

    // Present a load for one edge and check it was taken.
    task automatic load(input int u, input logic [7:0] d, input logic [3:0] fl,
                        input logic pt, input logic keep_valid);
        p_data[u]     = d;
        frame_len[u]  = fl;
        par_type[u]   = pt;
        data_valid[u] = 1'b1;
        ser_en[u]     = 1'b0;
        chk("load_ready_before", 32'(data_ready[u]), 32'd1);
        step();
        if (!keep_valid) data_valid[u] = 1'b0;
        chk("load_busy", 32'(ser_busy[u]), 32'd1);
        chk("load_ready_low", 32'(data_ready[u]), 32'd0);
        chk("load_out_idle", 32'(ser_out[u]), 32'd1);
        chk("load_cnt", 32'(counter[u]), 32'd0);
        chk("load_par", 32'(par_bit[u]), 32'(ref_par(d, fl, pt)));
    endtask

    // Run a loaded frame to completion with a tick every 'period' cycles,
    // checking every cycle against the expected bit sequence.
    task automatic stream(input int u, input logic [7:0] d, input logic [3:0] fl,
                          input logic pt, input int period, input logic clear_valid);
        int   len;
        int   ticks;
        int   cyc;
        logic bits [8];
        logic epar;
        len  = eff_len(fl);
        epar = ref_par(d, fl, pt);
        for (int k = 0; k < 8; k++) bits[k] = 1'b0;
        for (int k = 0; k < len; k++) bits[k] = (u == 1) ? d[len-1-k] : d[k];
        $display("[TB] frame dut=%0d data=%02h len=%0d par_type=%0d period=%0d", u, d, len, pt, period);
        ticks = 0;
        cyc   = 0;
        while (ticks <= len) begin
            ser_en[u] = ((cyc % period) == (period - 1));
            if (ser_en[u] && ticks == len && clear_valid) data_valid[u] = 1'b0;
            cyc++;
            step();
            if (ser_en[u]) ticks++;
            if (ticks == len + 1) begin
                chk("end_done", 32'(ser_done[u]), 32'd1);
                chk("end_out", 32'(ser_out[u]), 32'd1);
                chk("end_cnt", 32'(counter[u]), 32'd0);
                chk("end_ready", 32'(data_ready[u]), 32'd1);
                chk("end_busy", 32'(ser_busy[u]), 32'd0);
            end else begin
                chk("bit_done_low", 32'(ser_done[u]), 32'd0);
                chk("bit_out", 32'(ser_out[u]), (ticks == 0) ? 32'd1 : 32'(bits[ticks-1]));
                chk("bit_cnt", 32'(counter[u]), 32'(ticks));
                chk("bit_busy", 32'(ser_busy[u]), 32'd1);
            end
            chk("frame_par", 32'(par_bit[u]), 32'(epar));
        end
        ser_en[u] = 1'b0;
    endtask

    initial begin
        int          base;
        int          u;
        logic [7:0]  d;
        logic [3:0]  fl;
        logic        pt;
        int          per;

        rst        = 1'b1;
        p_data     = '0;
        frame_len  = '0;
        par_type   = '0;
        data_valid = '0;
        ser_en     = '0;
        step();
        step();

        // Reset values on both instances.
        for (int i = 0; i < 2; i++) begin
            chk("rst_out", 32'(ser_out[i]), 32'd1);
            chk("rst_ready", 32'(data_ready[i]), 32'd1);
            chk("rst_busy", 32'(ser_busy[i]), 32'd0);
            chk("rst_done", 32'(ser_done[i]), 32'd0);
            chk("rst_cnt", 32'(counter[i]), 32'd0);
            chk("rst_par", 32'(par_bit[i]), 32'd0);
        end
        rst = 1'b0;

        // Ticks in IDLE without a load have no effect.
        ser_en = 2'b11;
        for (int c = 0; c < 4; c++) begin
            step();
            $display("[TB] idle tick cycle %0d", c);
            for (int i = 0; i < 2; i++) begin
                chk("idle_out", 32'(ser_out[i]), 32'd1);
                chk("idle_ready", 32'(data_ready[i]), 32'd1);
                chk("idle_done", 32'(ser_done[i]), 32'd0);
                chk("idle_cnt", 32'(counter[i]), 32'd0);
            end
        end
        ser_en = 2'b00;

        // LSB-first full frame, tick every cycle.
        load(0, 8'hA5, 4'd0, 1'b0, 1'b0);
        chk("a5_par", 32'(par_bit[0]), 32'd0);
        stream(0, 8'hA5, 4'd0, 1'b0, 1, 1'b1);

        // MSB-first 5-bit frame, odd parity, tick every 4th cycle.
        load(1, 8'hF3, 4'd5, 1'b1, 1'b0);
        chk("f3_par", 32'(par_bit[1]), 32'd0);
        stream(1, 8'hF3, 4'd5, 1'b1, 4, 1'b1);

        // Load attempt during SHIFT must be ignored.
        load(0, 8'h0F, 4'd0, 1'b0, 1'b0);
        p_data[0]     = 8'hFF;
        frame_len[0]  = 4'd3;
        data_valid[0] = 1'b1;
        stream(0, 8'h0F, 4'd0, 1'b0, 2, 1'b1);
        step();
        chk("inject_not_loaded", 32'(ser_busy[0]), 32'd0);
        chk("inject_par_kept", 32'(par_bit[0]), 32'd0);

        // Back-to-back frames with Data_Valid held high.
        base = done_seen0;
        load(0, 8'h01, 4'd0, 1'b0, 1'b1);
        p_data[0] = 8'h80;
        stream(0, 8'h01, 4'd0, 1'b0, 1, 1'b0);
        load(0, 8'h80, 4'd0, 1'b0, 1'b0);
        stream(0, 8'h80, 4'd0, 1'b0, 1, 1'b1);
        @(negedge clk);
        #1;
        chk("b2b_done_count", 32'(done_seen0 - base), 32'd2);

        // Reset in the middle of a frame.
        base = done_seen0;
        load(0, 8'hC3, 4'd0, 1'b0, 1'b0);
        ser_en[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("pre_rst_bit", 32'(ser_out[0]), 32'(k < 2 ? 1 : 0));
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        ser_en[0] = 1'b0;
        $display("[TB] mid-frame reset");
        chk("mrst_out", 32'(ser_out[0]), 32'd1);
        chk("mrst_cnt", 32'(counter[0]), 32'd0);
        chk("mrst_ready", 32'(data_ready[0]), 32'd1);
        chk("mrst_done", 32'(ser_done[0]), 32'd0);
        step();
        chk("mrst_no_done", 32'(done_seen0 - base), 32'd0);
        load(0, 8'h3C, 4'd6, 1'b1, 1'b0);
        stream(0, 8'h3C, 4'd6, 1'b1, 1, 1'b1);

        // Random frames on both instances, including out-of-range lengths.
        for (int n = 0; n < 16; n++) begin
            u   = int'($urandom_range(0, 1));
            d   = 8'($urandom);
            fl  = 4'($urandom_range(0, 15));
            pt  = 1'($urandom);
            per = int'($urandom_range(1, 3));
            load(u, d, fl, pt, 1'b0);
            stream(u, d, fl, pt, per, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
